mac_group_accumulator: RTL and testbench
========================================

# mac_group_accumulator

Downstream consumer of the multiply-accumulate stage: accepts its signed 32-bit result stream `y` over a valid/ready handshake and sums consecutive results in groups of `N`. Each completed group is emitted as one widened, overflow-free signed sum with its sample count. A group can also close early via `in_last`. It uses the same handshake rule as the producing stage, so the two chain with no glue logic.

## Interface
- `N`, 4: samples per full group, 1..256.
- `IN_W`, 32: input sample width, signed.
- `OUT_W`, `IN_W + $clog2(N)`: sum width, signed; derived, not to be overridden.
- `CNT_W`, `$clog2(N+1)`: count width; derived.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: upstream sample valid.
- `in_ready`  out  1: block can accept a sample this cycle.
- `y_in`  in  IN_W: signed sample.
- `in_last`  in  1: qualified by `in_valid`; this sample closes the current group.
- `out_valid`  out  1: `sum`/`count`/`out_partial` valid.
- `out_ready`  in  1: downstream accepts output.
- `sum`  out  OUT_W: signed group sum.
- `count`  out  CNT_W: number of samples in `sum`, 1..N.
- `out_partial`  out  1: `count < N` (group closed by `in_last`).

## Operation
- Internal state: `acc` (OUT_W, signed) and `cnt` (CNT_W), holding the open group.
- Output registers: `out_valid`, `sum`, `count`, `out_partial`.
- `in_ready = !out_valid || out_ready`. Combinational; no dependence on `in_valid`, `y_in` or `in_last`.
- Accept occurs when `in_valid && in_ready`. Let `s = sext(y_in)` to OUT_W and `c = cnt + 1`.
  - Completing accept (`c == N` or `in_last`):
    - `sum <= acc + s`, `count <= c`, `out_partial <= (c != N)`, `out_valid <= 1`.
    - `acc <= 0`, `cnt <= 0`.
  - Non-completing accept: `acc <= acc + s`, `cnt <= c`. If `out_ready`, then `out_valid <= 0`.
- No accept, with `out_valid && out_ready`: `out_valid <= 0`. `sum`/`count` keep their stale values.
- No accept, with `out_valid && !out_ready`: all output registers hold; `in_ready = 0` stalls upstream mid-group. `acc` and `cnt` hold.
- Arithmetic: two's-complement, sign-extended, never wraps. Worst case `N * -2^(IN_W-1)` fits OUT_W.
- `N == 1`: every accepted sample is emitted; `out_partial` is always 0.
- `in_last` on the first sample of a group emits `count = 1`. `in_last` on the Nth sample emits a full group with `out_partial = 0`.
- `in_last` without `in_valid` is ignored.

## Timing
- Reset value of every output and state register is 0: `out_valid`, `sum`, `count`, `out_partial`, `acc`, `cnt`.
- `in_ready` is 1 out of reset.
- Reset asserted mid-group discards the partial group and any pending output. There is no flush.
- Latency: the completing sample is accepted at edge k; `out_valid` is high from edge k to the next edge.
- Throughput: one sample per cycle sustained while `out_ready` is held high. No bubble at group boundaries.
- A completing accept and an output pop in the same cycle are legal: the old result leaves and the new result loads in the same edge.
- While `out_valid && !out_ready`: `sum`, `count` and `out_partial` are stable and `in_ready = 0`.

## Structure
- Shared package holds:
  - `MAC_Y_W = 32`, the producer output width, used as the `IN_W` default.
  - A `sum_width(IN_W, N)` function for OUT_W, so instantiating parents size buses identically.
- Single module, no sub-module: one accumulate path plus one output register. Expected size is about 120–150 lines.

## Test plan
- Reset then drive `y_in` = 10, -3, 7, 100 back-to-back with `out_ready = 1` and N = 4:
  - Exactly one output, `sum = 114`, `count = 4`, `out_partial = 0`.
  - It appears the cycle after the 4th accept.
  - `in_ready` stays 1 throughout.
- Extremes, N = 4: four samples of `-2^31`, then four of `2^31 - 1`.
  - Expect `sum = -2^33`, then `sum = 2^33 - 4`, with no wrap.
- `in_last` early exit:
  - Samples 5, 6 with `in_last` on 6 → `sum = 11`, `count = 2`, `out_partial = 1`.
  - Next group then starts from 0.
  - Single sample 9 with `in_last` → `count = 1`.
- Backpressure:
  - Complete a group, hold `out_ready = 0` for 5 cycles. Expect `in_ready = 0` and `sum` stable throughout.
  - Raise `out_ready` while presenting the final sample of the next group. Old result pops and new result loads in the same edge.
- Reset mid-group: accept 2 of 4 samples, assert `rst` one cycle.
  - All outputs read 0.
  - The next 4 samples (1, 1, 1, 1) give `sum = 4`, with no residue from before reset.
- Continuous stream of 12 samples, N = 4, `out_ready` toggling randomly:
  - Three outputs whose sums match a scoreboard.
  - No sample dropped or duplicated.

Source files
------------

// File: rtl/mac_group_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// mac_group_accumulator_pkg
// Shared constants and helpers for the MAC group accumulator and its parents.
//   MAC_Y_W   : width of the multiply-accumulate producer's result stream.
//   sum_width : widened sum width for a group of n samples of in_w bits, so
//               every instantiating parent sizes its buses identically.
// ---------------------------------------------------------------------------
package mac_group_accumulator_pkg;

  localparam int MAC_Y_W = 32;

  // A group of n samples needs ceil(log2(n)) extra bits to never wrap.
  function automatic int sum_width(input int in_w, input int n);
    return in_w + $clog2(n);
  endfunction

endpackage

// File: rtl/mac_group_accumulator.sv
// ---------------------------------------------------------------------------
// mac_group_accumulator
// Sums consecutive signed samples in groups of N and emits each group as one
// widened signed sum with its sample count. A group closes early on in_last.
//
// Ports:
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   in_valid     : upstream sample valid
//   in_ready     : block accepts a sample this cycle
//   y_in         : signed input sample (IN_W bits)
//   in_last      : with in_valid, this sample closes the current group
//   out_valid    : sum / count / out_partial are valid
//   out_ready    : downstream accepts the output
//   sum          : signed group sum (OUT_W bits)
//   count        : samples in sum, 1..N
//   out_partial  : group closed by in_last before reaching N samples
// ---------------------------------------------------------------------------
module mac_group_accumulator
  import mac_group_accumulator_pkg::*;
#(
  parameter int N = 4,
  parameter int IN_W = MAC_Y_W,
  localparam int OUT_W = sum_width(IN_W, N),
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  y_in,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] sum,
  output logic [CNT_W-1:0] count,
  output logic             out_partial
);

  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_partial_q, out_partial_d;

  logic signed [IN_W-1:0] y_signed;
  logic [OUT_W-1:0]       sample_ext;
  logic [OUT_W-1:0]       acc_sum;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   accept;
  logic                   group_done;

  // Ready whenever the output slot is empty or is being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign y_signed = y_in;

  // Next-state logic for the open group and the output register.
  always_comb begin
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q;
    sum_d         = sum_q;
    count_d       = count_q;
    out_partial_d = out_partial_q;

    // Sized cast of a signed operand sign-extends to the full sum width.
    sample_ext = OUT_W'(y_signed);
    acc_sum    = acc_q + sample_ext;
    cnt_inc    = cnt_q + CNT_W'(1'b1);
    accept     = in_valid && in_ready;
    group_done = (cnt_inc == N_CNT) || in_last;

    if (accept && group_done) begin
      // Loads over any result being popped in the same edge.
      sum_d         = acc_sum;
      count_d       = cnt_inc;
      out_partial_d = (cnt_inc != N_CNT);
      out_valid_d   = 1'b1;
      acc_d         = {OUT_W{1'b0}};
      cnt_d         = {CNT_W{1'b0}};
    end else if (accept) begin
      acc_d = acc_sum;
      cnt_d = cnt_inc;
      if (out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end else if (out_valid_q && out_ready) begin
      // Pop only; sum/count keep their stale values.
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q         <= {OUT_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      out_valid_q   <= 1'b0;
      sum_q         <= {OUT_W{1'b0}};
      count_q       <= {CNT_W{1'b0}};
      out_partial_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      sum_q         <= sum_d;
      count_q       <= count_d;
      out_partial_q <= out_partial_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign sum         = sum_q;
  assign count       = count_q;
  assign out_partial = out_partial_q;

endmodule

// File: tb/tb_mac_group_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mac_group_accumulator
// Scoreboard bench: the driver feeds samples into a queue-based group model
// that pushes expected results; a negedge monitor pops and compares whenever
// the DUT hands an output downstream.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mac_group_accumulator;
  import mac_group_accumulator_pkg::*;

  localparam int N     = 4;
  localparam int IN_W  = MAC_Y_W;
  localparam int OUT_W = sum_width(IN_W, N);
  localparam int CNT_W = $clog2(N + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  y_in = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] sum;
  logic [CNT_W-1:0] count;
  logic             out_partial;

  logic signed [OUT_W-1:0] sum_sg;
  assign sum_sg = sum;

  typedef struct {
    longint sum;
    int     count;
    bit     partial;
  } result_t;

  result_t sbq[$];   // expected results not yet popped
  longint  grp[$];   // samples of the open group
  int checks = 0;
  int passed = 0;
  int pops   = 0;

  always #5 clk = ~clk;

  mac_group_accumulator #(.N(N), .IN_W(IN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .y_in(y_in), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .count(count), .out_partial(out_partial)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: collect samples, close on N or last, sum with plain arithmetic.
  task automatic model_accept(input longint y, input bit last);
    result_t r;
    grp.push_back(y);
    if (grp.size() == N || last) begin
      r.sum = 0;
      foreach (grp[i]) r.sum += grp[i];
      r.count   = grp.size();
      r.partial = (grp.size() != N);
      sbq.push_back(r);
      grp.delete();
    end
  endtask

  // Present one sample from posedge+1 until accepted; returns at posedge+1.
  task automatic send(input longint y, input bit last, input bit rnd_ready);
    int waited = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    y_in     = IN_W'(y);
    in_last  = last;
    while (!done) begin
      @(negedge clk); #1;
      if (in_ready) begin
        model_accept(y, last);
        done = 1'b1;
      end else if (waited > 40) begin
        checks++;
        $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", waited);
        done = 1'b1;
      end
      waited++;
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n, input bit rnd_ready);
    repeat (n) begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Monitor: handshake sanity each cycle, scoreboard compare on every pop.
  always @(negedge clk) begin : mon
    result_t e;
    if (!rst) begin
      check("out_valid", out_valid, sbq.size() != 0);
      check("in_ready", in_ready, (sbq.size() == 0) || out_ready);
      if (out_valid && out_ready && sbq.size() != 0) begin
        e = sbq.pop_front();
        pops++;
        check("sum", sum_sg, e.sum);
        check("count", count, e.count);
        check("out_partial", out_partial, e.partial);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int     pops0;
    int     rv;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum_sg, 0);
    check("rst_count", count, 0);
    check("rst_partial", out_partial, 0);
    check("rst_in_ready", in_ready, 1);

    // Basic full group with one-cycle latency
    out_ready = 1'b1;
    send(10, 1'b0, 1'b0);
    send(-3, 1'b0, 1'b0);
    send(7, 1'b0, 1'b0);
    check("t1_no_early_out", out_valid, 0);
    send(100, 1'b0, 1'b0);
    check("t1_out_valid", out_valid, 1);
    check("t1_sum", sum_sg, 114);
    check("t1_count", count, 4);
    idle(2, 1'b0);

    // Extremes: no wrap in the widened sum
    repeat (4) send(-64'sd2147483648, 1'b0, 1'b0);
    check("ext_min_sum", sum_sg, -64'sd8589934592);
    repeat (4) send(64'sd2147483647, 1'b0, 1'b0);
    check("ext_max_sum", sum_sg, 64'sd8589934588);
    idle(1, 1'b0);

    // Early close by in_last, then fresh group, then single-sample group
    send(5, 1'b0, 1'b0);
    send(6, 1'b1, 1'b0);
    check("last_sum", sum_sg, 11);
    check("last_count", count, 2);
    check("last_partial", out_partial, 1);
    send(1, 1'b0, 1'b0);
    send(2, 1'b0, 1'b0);
    send(3, 1'b0, 1'b0);
    send(4, 1'b0, 1'b0);
    check("fresh_sum", sum_sg, 10);
    check("fresh_partial", out_partial, 0);
    send(9, 1'b1, 1'b0);
    check("single_count", count, 1);
    check("single_sum", sum_sg, 9);
    idle(1, 1'b0);

    // Backpressure: hold a result, then pop and load in the same edge
    out_ready = 1'b0;
    send(20, 1'b0, 1'b0);
    send(21, 1'b0, 1'b0);
    send(22, 1'b0, 1'b0);
    send(23, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_sum_stable", sum_sg, 86);
      check("bp_out_valid", out_valid, 1);
      idle(1, 1'b0);
    end
    out_ready = 1'b1;
    send(42, 1'b1, 1'b0);
    check("bp_swap_valid", out_valid, 1);
    check("bp_swap_sum", sum_sg, 42);
    check("bp_swap_count", count, 1);
    idle(1, 1'b0);

    // Reset mid-group discards the partial sum
    send(50, 1'b0, 1'b0);
    send(60, 1'b0, 1'b0);
    rst = 1'b1;
    sbq.delete();
    grp.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum_sg, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_partial", out_partial, 0);
    repeat (4) send(1, 1'b0, 1'b0);
    check("post_rst_sum", sum_sg, 4);
    check("post_rst_count", count, 4);
    idle(1, 1'b0);

    // Random stream with random backpressure and idle gaps
    pops0 = pops;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 2) == 0) idle(1, 1'b1);
      rv = int'($urandom());
      send(longint'(rv), 1'b0, 1'b1);
    end
    out_ready = 1'b1;
    idle(4, 1'b0);
    check("rand_outputs", pops - pops0, 3);
    check("rand_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
